// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   Operand-fetch stage for the tinyRISC core. Holds the architectural
//   register file, picks the two operands for each instruction class
//   (return, store, ALU/default), forwards same-cycle writeback data and
//   stalls read-after-write hazards with a per-register busy scoreboard.
//   A one-entry output register decouples the stage from execute.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid / in_ready         decode handshake
//   in_inst                     instruction word, carried through unchanged
//   in_is_ret, in_is_st         instruction class
//   in_rs1, in_rs2, in_rd       register indices (in_rd is store data source)
//   in_wb                       instruction will write in_rd
//   wb_en, wb_addr, wb_data     writeback port
//   out_valid / out_ready       execute handshake
//   out_inst, out_op1, out_op2  registered instruction and operands
module operand_fetch_stage #(
  parameter int XLEN   = 32,
  parameter int NREG   = 16,
  parameter int RA_IDX = 15,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic            in_is_ret,
  input  logic            in_is_st,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_wb,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2
);

  localparam logic [AW-1:0] RA_SEL = AW'(RA_IDX);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_inst_q, out_inst_d;
  logic [XLEN-1:0] out_op1_q, out_op1_d;
  logic [XLEN-1:0] out_op2_q, out_op2_d;

  logic [AW-1:0]   src_a, src_b;
  logic            use_b;
  logic [XLEN-1:0] val_a, val_b;
  logic            byp_a, byp_b;
  logic            hazard;
  logic            accept;

  // Source selection per instruction class; return has priority over store.
  always_comb begin
    src_a = in_rs1;
    src_b = in_rs2;
    use_b = 1'b1;
    if (in_is_ret) begin
      src_a = RA_SEL;
      src_b = '0;
      use_b = 1'b0;
    end else if (in_is_st) begin
      src_b = in_rd;
    end
  end

  // Writeback in the current cycle both supplies the value and resolves
  // the hazard on that index, so the dependent instruction issues now.
  assign byp_a = wb_en && (wb_addr == src_a);
  assign byp_b = wb_en && (wb_addr == src_b);
  assign val_a = byp_a ? wb_data : regs_q[src_a];
  assign val_b = byp_b ? wb_data : regs_q[src_b];

  assign hazard   = (busy_q[src_a] && !byp_a) ||
                    (use_b && busy_q[src_b] && !byp_b);
  assign in_ready = !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    regs_d      = regs_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;

    if (wb_en) begin
      regs_d[wb_addr] = wb_data;
      busy_d[wb_addr] = 1'b0;
    end
    // Set after clear so a same-cycle collision leaves the register busy.
    if (accept && in_wb) begin
      busy_d[in_rd] = 1'b1;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_inst_d  = in_inst;
      out_op1_d   = val_a;
      out_op2_d   = use_b ? val_b : '0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
    end else begin
      regs_q      <= regs_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_op1   = out_op1_q;
  assign out_op2   = out_op2_q;

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Parametrised operand-fetch pipeline stage for the tinyRISC core. Holds the architectural register file, selects the two operands per instruction class (return, store, ALU/default), bypasses same-cycle writeback data, and stalls on read-after-write hazards using a per-register busy scoreboard. Sits between decode and execute; a valid/ready handshake and a one-entry output register decouple it from the execute stage.

## Interface
- XLEN, 32, data width of registers and operands
- NREG, 16, number of architectural registers (power of two, ≥ 2)
- RA_IDX, 15, index of the return-address register read on a return
- AW, $clog2(NREG), register index width (derived, not overridden)

- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset: synchronous and active-low
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_inst  in  32  instruction word, carried through unchanged
- in_is_ret  in  1  return instruction
- in_is_st  in  1  store instruction
- in_rs1  in  AW  first source index
- in_rs2  in  AW  second source index
- in_rd  in  AW  destination index (store-data source when in_is_st)
- in_wb  in  1  instruction will write in_rd
- wb_en  in  1  writeback strobe
- wb_addr  in  AW  writeback index
- wb_data  in  XLEN  writeback data
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  execute accepts the output
- out_inst  out  32  registered instruction word
- out_op1  out  XLEN  registered operand 1
- out_op2  out  XLEN  registered operand 2

## Operation
- Operand selection:
  - in_is_ret: op1 = R[RA_IDX], op2 = 0. Sources used: RA_IDX.
  - in_is_st (and not ret): op1 = R[in_rs1], op2 = R[in_rd]. Sources used: rs1, rd.
  - Otherwise: op1 = R[in_rs1], op2 = R[in_rs2]. Sources used: rs1, rs2.
  - in_is_ret has priority over in_is_st.
- Read value for index i: wb_data if wb_en and wb_addr == i, else R[i]. No hardwired-zero register.
- Scoreboard busy[NREG]:
  - Hazard when any used source s has busy[s] = 1 and not (wb_en and wb_addr == s).
  - On accept with in_wb: set busy[in_rd].
  - On wb_en: clear busy[wb_addr].
  - Same-cycle clear and set of the same index: set wins.
- Handshake:
  - in_ready = !hazard and (!out_valid or out_ready).
  - Accept = in_valid and in_ready.
  - On accept, the output register loads inst/op1/op2 and out_valid = 1.
  - On out_ready with no accept: out_valid = 0.
  - Output holds stable while out_valid and !out_ready.
- Register file: when wb_en, R[wb_addr] ← wb_data.
- Reset (rst_n = 0 at an edge):
  - All R cleared to 0, busy all 0, out_valid = 0, out_inst/out_op1/out_op2 = 0.
  - Reset overrides any simultaneous wb or accept.

## Timing
- Latency: one cycle from accept to out_valid with operands.
- Throughput: one instruction per cycle with no hazard and out_ready held high.
- Bypass is combinational. A writeback in cycle N satisfies a read in cycle N, and the accept completes that same cycle.
- Hazard stall lasts until the producing writeback cycle. The dependent instruction is accepted in that cycle, not one later.
- in_ready depends combinationally on out_ready, in_rs*/in_rd/in_is_* and wb_*. It never depends on in_valid.

## Test plan
- Reset then default op:
  - Stimulus: wb R3 = 0x11, R4 = 0x22, then issue rs1 = 3, rs2 = 4.
  - Required: out_op1 = 0x11, out_op2 = 0x22 one cycle after accept.
  - Required: all outputs read 0 during reset.
- Return:
  - Stimulus: R15 = 0x0000_0100, issue in_is_ret with rs1 = 2.
  - Required: op1 = 0x100, op2 = 0.
  - Stimulus: issue with in_is_ret = in_is_st = 1.
  - Required: same result (ret wins).
- Store:
  - Stimulus: R1 = 0x40, R5 = 0xDEAD_BEEF, issue in_is_st with rs1 = 1, rd = 5.
  - Required: op1 = 0x40, op2 = 0xDEADBEEF.
- RAW hazard:
  - Stimulus: accept instruction with in_wb, rd = 7, then present a read of R7.
  - Required: in_ready = 0 for 3 cycles until wb_en with wb_addr = 7, wb_data = 0x55.
  - Required: accepted in the wb cycle with op1 = 0x55; busy[7] = 0 afterwards.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 4 cycles with out_valid = 1.
  - Required: out_* stable and in_ready = 0.
  - Stimulus: release out_ready.
  - Required: the pending input is accepted in the same cycle and out_valid stays 1.
- Set/clear collision and mid-operation reset:
  - Stimulus: wb to R6 while accepting a new in_wb with rd = 6.
  - Required: busy[6] = 1 afterwards.
  - Stimulus: assert rst_n = 0 with out_valid = 1 and busy bits set.
  - Required: out_valid = 0 and busy all 0 next cycle.
